// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the control unit: loadable instruction memory plus a PC.
// Each word is held on instr for the number of cycles its class needs before the next is issued.
module instr_fetch #(
  parameter int unsigned INSTR_WIDTH = 20,
  parameter int unsigned PC_BITS     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   run,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_BITS-1:0]     pc,
  output logic                   issue,
  output logic                   busy,
  output logic                   halted
);

  localparam int unsigned DEPTH = 2 ** PC_BITS;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_HALT
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   issue_q, issue_d;
  logic                   busy_q, busy_d;
  logic                   halted_q, halted_d;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic                   mem_we;
  logic [PC_BITS-1:0]     next_addr;
  logic [INSTR_WIDTH-1:0] next_word;
  logic [INSTR_WIDTH-1:0] first_word;

  // Remaining hold count after issue: L-1, where loadR needs 4 cycles, others 3, first word +1.
  function automatic logic [CNT_W-1:0] hold_cnt(input logic [1:0] cls, input logic first);
    logic [CNT_W-1:0] c;
    c = (cls == 2'b10) ? CNT_W'(3) : CNT_W'(2);
    if (first) c = c + CNT_W'(1);
    return c;
  endfunction

  assign next_addr  = pc_q + PC_BITS'(1);
  assign next_word  = mem[next_addr];
  assign first_word = mem[0];

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    issue_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_d = '0;
        if (load_en) begin
          mem_we = 1'b1;
        end else if (run) begin
          pc_d = '0;
          if (first_word[INSTR_WIDTH-1 -: 2] != 2'b00) begin
            state_d = ST_HOLD;
            instr_d = first_word;
            cnt_d   = hold_cnt(first_word[INSTR_WIDTH-1 -: 2], 1'b1);
            issue_d = 1'b1;
          end else begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (pc_q == '1) begin
          // End of memory: stop rather than wrap to address 0.
          state_d = ST_HALT;
          instr_d = '0;
        end else if (next_word[INSTR_WIDTH-1 -: 2] == 2'b00) begin
          state_d = ST_HALT;
          pc_d    = next_addr;
          instr_d = '0;
        end else begin
          instr_d = next_word;
          pc_d    = next_addr;
          cnt_d   = hold_cnt(next_word[INSTR_WIDTH-1 -: 2], 1'b0);
          issue_d = 1'b1;
        end
      end
      ST_HALT: begin
        instr_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        instr_d = '0;
      end
    endcase
    busy_d   = (state_d == ST_HOLD);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      issue_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      issue_q  <= issue_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  // Memory survives reset so a program can be re-run without reloading.
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr] <= load_data;
  end

  assign instr  = instr_q;
  assign pc     = pc_q;
  assign issue  = issue_q;
  assign busy   = busy_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: hold timing per class, halt on 00-class or end of memory,
// load/run priority and asynchronous reset mid-hold.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [19:0] load_data;
  logic        run;
  logic [19:0] instr;
  logic [4:0]  pc;
  logic        issue;
  logic        busy;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch #(.INSTR_WIDTH(20), .PC_BITS(5)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .run(run), .instr(instr), .pc(pc),
    .issue(issue), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load_en = 1'b0; run = 1'b0; load_addr = '0; load_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic load(input logic [4:0] a, input logic [19:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  task automatic load_prog2();
    load(5'd0, 20'h4_1201);
    load(5'd1, 20'h8_4050);
    load(5'd2, 20'hC_4060);
    load(5'd3, 20'h0_0000);
  endtask

  initial begin
    int n_issue;
    int halt_at;

    // Reset state
    do_reset();
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_issue", 32'(issue), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);

    // 1: single std_op, first word held 4 cycles, then halt on 00 word
    load(5'd0, 20'h5_1230);
    load(5'd1, 20'h0_0000);
    pulse_run();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s1_instr_c%0d", i), 32'(instr), 32'h5_1230);
      check($sformatf("s1_pc_c%0d", i), 32'(pc), 32'h0);
      check($sformatf("s1_issue_c%0d", i), 32'(issue), (i == 0) ? 32'h1 : 32'h0);
      check($sformatf("s1_busy_c%0d", i), 32'(busy), 32'h1);
      step();
    end
    check("s1_halt_instr", 32'(instr), 32'h0);
    check("s1_halt_pc", 32'(pc), 32'h1);
    check("s1_halted", 32'(halted), 32'h1);
    check("s1_halt_busy", 32'(busy), 32'h0);

    // 2: std_op(first, 4) / loadR(4) / storeR(3) -> issues at 0,4,8; halt at 11 with pc=3
    do_reset();
    load_prog2();
    pulse_run();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("s2_issue_c%0d", i), 32'(issue), (i == 0 || i == 4 || i == 8) ? 32'h1 : 32'h0);
      check($sformatf("s2_halted_c%0d", i), 32'(halted), (i >= 11) ? 32'h1 : 32'h0);
      if (i == 4) check("s2_instr_loadR", 32'(instr), 32'h8_4050);
      if (i == 8) check("s2_instr_storeR", 32'(instr), 32'hC_4060);
      if (i == 10) check("s2_pc_storeR_held", 32'(pc), 32'h2);
      step();
    end
    check("s2_halt_pc", 32'(pc), 32'h3);
    check("s2_halt_instr", 32'(instr), 32'h0);

    // 3: mem[0] is a 00 word -> direct halt, no issue
    do_reset();
    load(5'd0, 20'h0_0000);
    pulse_run();
    check("s3_halted", 32'(halted), 32'h1);
    check("s3_issue", 32'(issue), 32'h0);
    check("s3_instr", 32'(instr), 32'h0);
    check("s3_pc", 32'(pc), 32'h0);
    step();
    check("s3_issue_after", 32'(issue), 32'h0);
    check("s3_still_halted", 32'(halted), 32'h1);

    // 4: full memory of std_op -> 32 issues, halt at pc=31 after 3-cycle hold, no wrap
    do_reset();
    for (int a = 0; a < 32; a++) load(5'(a), 20'h4_0000);
    pulse_run();
    n_issue = 0;
    halt_at = -1;
    for (int i = 0; i < 105; i++) begin
      if (issue) n_issue++;
      if (halted && halt_at < 0) halt_at = i;
      if (i == 94) begin
        check("s4_last_issue", 32'(issue), 32'h1);
        check("s4_last_pc", 32'(pc), 32'd31);
      end
      step();
    end
    check("s4_issue_count", 32'(n_issue), 32'd32);
    check("s4_halt_cycle", 32'(halt_at), 32'd97);
    check("s4_halt_pc", 32'(pc), 32'd31);
    check("s4_halt_instr", 32'(instr), 32'h0);

    // 5: load has priority over run in the same IDLE cycle
    do_reset();
    load_en = 1'b1; run = 1'b1; load_addr = 5'd0; load_data = 20'h4_1111;
    step();
    load_en = 1'b0; run = 1'b0;
    check("s5_idle_busy", 32'(busy), 32'h0);
    check("s5_idle_issue", 32'(issue), 32'h0);
    check("s5_idle_instr", 32'(instr), 32'h0);
    check("s5_idle_halted", 32'(halted), 32'h0);
    pulse_run();
    check("s5_run_instr", 32'(instr), 32'h4_1111);
    check("s5_run_issue", 32'(issue), 32'h1);
    check("s5_run_pc", 32'(pc), 32'h0);

    // 6: async reset during the 2nd hold cycle, then re-run from retained memory
    do_reset();
    load_prog2();
    pulse_run();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("s6_async_instr", 32'(instr), 32'h0);
    check("s6_async_pc", 32'(pc), 32'h0);
    check("s6_async_busy", 32'(busy), 32'h0);
    check("s6_async_issue", 32'(issue), 32'h0);
    step();
    rst = 1'b0;
    check("s6_idle_after_rst", 32'(busy), 32'h0);
    pulse_run();
    check("s6_rerun_instr0", 32'(instr), 32'h4_1201);
    check("s6_rerun_issue0", 32'(issue), 32'h1);
    for (int i = 0; i < 4; i++) step();
    check("s6_rerun_instr1", 32'(instr), 32'h8_4050);
    check("s6_rerun_pc1", 32'(pc), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
